// File: rtl/la_wb_arb_pkg.sv
// Shared types and constants for the la_wb two-master Wishbone arbiter.
package la_wb_arb_pkg;

    localparam int unsigned DefaultAw = 32;
    localparam int unsigned DefaultDw = 32;

    // Read data returned to a master whose slave access timed out
    localparam logic [31:0] TimeoutData = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/la_wb_arb_rr.sv
// Two-request round-robin grant picker; on contention the master that was
// not granted last wins.
module la_wb_arb_rr (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_gnt_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/la_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter in front of the la_wb register slave.
// Optional slave-ack timeout is enabled by defining LA_WB_ARB_TIMEOUT_EN.
module la_wb_arbiter
    import la_wb_arb_pkg::*;
#(
    parameter int unsigned AW             = DefaultAw,
    parameter int unsigned DW             = DefaultDw,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic [DW-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic            timeout_o
);

    arb_state_e state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic [1:0] req, gnt;
    logic       stb_raw;
    logic       to_hit;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    la_wb_arb_rr u_rr (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    // last_gnt resets to 1 so master 0 wins the first contention
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (gnt[0]) state_d = StGnt0;
                else if (gnt[1]) state_d = StGnt1;
            end
            StGnt0:  if (!m0_cyc_i) state_d = req[1] ? StGnt1 : StIdle;
            StGnt1:  if (!m1_cyc_i) state_d = req[0] ? StGnt0 : StIdle;
            default: state_d = StIdle;
        endcase

        last_gnt_d = last_gnt_q;
        if (state_d == StGnt0) last_gnt_d = 1'b0;
        else if (state_d == StGnt1) last_gnt_d = 1'b1;
    end

    always_comb begin
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        unique case (state_q)
            StGnt0: begin
                s_cyc_o = m0_cyc_i;
                stb_raw = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            StGnt1: begin
                s_cyc_o = m1_cyc_i;
                stb_raw = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: begin
            end
        endcase
    end

    // A timed-out access is withdrawn from the slave and acked locally
    assign s_stb_o  = stb_raw & ~to_hit;
    assign m0_ack_o = (state_q == StGnt0) & (s_ack_i | to_hit);
    assign m1_ack_o = (state_q == StGnt1) & (s_ack_i | to_hit);
    assign m0_dat_o = to_hit ? DW'(TimeoutData) : s_dat_i;
    assign m1_dat_o = to_hit ? DW'(TimeoutData) : s_dat_i;

`ifdef LA_WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    assign to_hit = stb_raw && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || s_ack_i || to_hit) cnt_d = '0;
        else if (stb_raw) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign to_hit                = 1'b0;
    assign timeout_o             = 1'b0;
`endif

endmodule

// File: tb/tb_la_wb_arbiter.sv
// Randomised bench for la_wb_arbiter: scripted masters, a memory slave with
// random ack latency and a transaction-level grant/data reference model.
module tb_la_wb_arbiter;

    localparam int unsigned Tmo = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          hold;
        int          gap;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][3:0]  m_sel;
    logic [1:0][31:0] m_adr, m_dat;
    logic             m0_ack, m1_ack;
    logic [31:0]      m0_rdat, m1_rdat;
    logic [1:0]       m_ack;
    logic [1:0][31:0] m_rdat;

    logic        s_cyc_o, s_stb_o, s_we_o, s_ack, timeout_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_rdat;

    assign m_ack  = {m1_ack, m0_ack};
    assign m_rdat = {m1_rdat, m0_rdat};

    always #5 clk = ~clk;

    la_wb_arbiter #(
        .AW             (32),
        .DW             (32),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_n),
        .m0_cyc_i  (m_cyc[0]),
        .m0_stb_i  (m_stb[0]),
        .m0_we_i   (m_we[0]),
        .m0_sel_i  (m_sel[0]),
        .m0_adr_i  (m_adr[0]),
        .m0_dat_i  (m_dat[0]),
        .m0_ack_o  (m0_ack),
        .m0_dat_o  (m0_rdat),
        .m1_cyc_i  (m_cyc[1]),
        .m1_stb_i  (m_stb[1]),
        .m1_we_i   (m_we[1]),
        .m1_sel_i  (m_sel[1]),
        .m1_adr_i  (m_adr[1]),
        .m1_dat_i  (m_dat[1]),
        .m1_ack_o  (m1_ack),
        .m1_dat_o  (m1_rdat),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_rdat),
        .timeout_o (timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, who was granted last, grant history
    int owner, last, handoffs;
    int grant_log[$];
    int ack_cnt[2];
    logic [31:0] last_rd[2];
    logic [31:0] ref_mem[16];

    // Bench slave and master drivers
    logic [31:0] slave_mem[16];
    int   s_wait;
    bit   slave_hang;
    bit   rand_mode;
    txn_t q0[$], q1[$];
    int   wait_c[2];
    bit   cur_hold[2];

    logic [1:0]       nx_cyc, nx_stb, nx_we;
    logic [1:0][3:0]  nx_sel;
    logic [1:0][31:0] nx_adr, nx_dat;
    logic             nx_ack;
    logic [31:0]      nx_sdat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int x);
        return (x == 0) ? q0.size() : q1.size();
    endfunction

    function automatic txn_t qfront(input int x);
        return (x == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int x, input txn_t t);
        if (x == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    task automatic qpop(input int x, output txn_t t);
        if (x == 0) t = q0.pop_front();
        else t = q1.pop_front();
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                input bit hold, input int gap);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.sel = 4'hF; t.hold = hold; t.gap = gap;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom);
        t.adr  = {26'd0, 4'($urandom), 2'b00};
        t.dat  = $urandom;
        t.sel  = 4'($urandom);
        t.hold = ($urandom_range(0, 2) == 0);
        t.gap  = $urandom_range(0, 3);
        return t;
    endfunction

    task automatic load(input int x, input txn_t t);
        nx_cyc[x] = 1'b1; nx_stb[x] = 1'b1; nx_we[x] = t.we;
        nx_sel[x] = t.sel; nx_adr[x] = t.adr; nx_dat[x] = t.dat;
        cur_hold[x] = t.hold;
    endtask

    task automatic check_cycle();
        logic [6:0]  e_ctl;
        logic [31:0] e_adr, e_dat;
        logic [1:0]  e_ack;
        e_ctl = '0; e_adr = '0; e_dat = '0; e_ack = '0;
        if (owner >= 0) begin
            e_ctl = {m_cyc[owner], m_stb[owner], m_we[owner], m_sel[owner]};
            e_adr = m_adr[owner];
            e_dat = m_dat[owner];
            e_ack[owner] = s_ack;
        end
        check_eq("s_ctl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o}, e_ctl);
        check_eq("s_adr", s_adr_o, e_adr);
        check_eq("s_dat", s_dat_o, e_dat);
        check_eq("m_ack", m_ack, e_ack);
        check_eq("m_rdat", m_rdat, {s_rdat, s_rdat});
        check_eq("timeout", timeout_o, 1'b0);
    endtask

    task automatic model_advance();
        logic [1:0] req;
        int nxt;
        req = m_cyc & m_stb;
        if (owner < 0) begin
            if (req == 2'b11) nxt = 1 - last;
            else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
            else nxt = -1;
        end else if (!m_cyc[owner]) begin
            nxt = req[1 - owner] ? 1 - owner : -1;
            if (nxt >= 0) handoffs++;
        end else begin
            nxt = owner;
        end
        if (nxt >= 0 && nxt != owner) begin
            last = nxt;
            grant_log.push_back(nxt);
        end
        owner = nxt;
    endtask

    // Whole-word memory slave; acks 1..3 cycles after it first sees stb
    task automatic slave_eval();
        int idx;
        idx = int'(s_adr_o[5:2]);
        nx_ack  = 1'b0;
        nx_sdat = $urandom;
        if (s_ack) begin
            if (s_we_o) slave_mem[idx] = s_dat_o;
        end else if (s_cyc_o && s_stb_o && !slave_hang) begin
            if (s_wait == 0) begin
                nx_ack = 1'b1;
                if (!s_we_o) nx_sdat = slave_mem[idx];
                s_wait = $urandom_range(0, 2);
            end else begin
                s_wait--;
            end
        end
    endtask

    task automatic drive_master(input int x);
        txn_t t;
        int idx;
        idx = int'(m_adr[x][5:2]);
        if (m_cyc[x] && m_stb[x] && m_ack[x]) begin
            ack_cnt[x]++;
            if (m_we[x]) ref_mem[idx] = m_dat[x];
            else begin
                check_eq(x == 0 ? "m0_rd_data" : "m1_rd_data", m_rdat[x], ref_mem[idx]);
                last_rd[x] = m_rdat[x];
            end
            if (cur_hold[x] && qsize(x) > 0) begin
                qpop(x, t);
                load(x, t);
            end else begin
                nx_cyc[x] = 1'b0;
                nx_stb[x] = 1'b0;
            end
        end else if (!m_cyc[x] && qsize(x) > 0) begin
            t = qfront(x);
            if (wait_c[x] < t.gap) wait_c[x]++;
            else begin
                qpop(x, t);
                load(x, t);
                wait_c[x] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        nx_cyc = m_cyc; nx_stb = m_stb; nx_we = m_we;
        nx_sel = m_sel; nx_adr = m_adr; nx_dat = m_dat;
        check_cycle();
        model_advance();
        slave_eval();
        if (rand_mode) begin
            for (int x = 0; x < 2; x++)
                if (qsize(x) < 2 && $urandom_range(0, 3) == 0) qpush(x, rand_txn());
        end
        drive_master(0);
        drive_master(1);
        @(posedge clk);
        #1;
        m_cyc = nx_cyc; m_stb = nx_stb; m_we = nx_we;
        m_sel = nx_sel; m_adr = nx_adr; m_dat = nx_dat;
        s_ack = nx_ack; s_rdat = nx_sdat;
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_cyc != 2'b00 || owner >= 0) && n < bound) begin
            cycle();
            n++;
        end
        check_eq("drain_in_bound", n < bound, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
        s_ack = 1'b0; s_rdat = '0;
        owner = -1; last = 1; handoffs = 0;
        grant_log.delete(); q0.delete(); q1.delete();
        ack_cnt[0] = 0; ack_cnt[1] = 0; wait_c[0] = 0; wait_c[1] = 0;
        s_wait = 0; slave_hang = 1'b0;
        #1;
        check_eq("rst_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
        check_eq("rst_ack", m_ack, 2'b00);
        check_eq("rst_timeout", timeout_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int stb_cycles, acks;
        bit got;
        logic [5:0] order;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            slave_mem[i] = '0;
        end
        rand_mode = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;

        // Solo write then read-back by m0, with 1-cycle arbitration latency
        do_reset();
        qpush(0, mk(1'b1, 32'h0000_0000, 32'hA5A5_1234, 1'b0, 0));
        qpush(0, mk(1'b0, 32'h0000_0000, 32'h0, 1'b0, 0));
        cycle();
        #1 check_eq("solo_lat_idle", s_stb_o, 1'b0);
        cycle();
        #1 check_eq("solo_lat_stb", s_stb_o, 1'b1);
        run_until_idle(50);
        check_eq("solo_readback", last_rd[0], 32'hA5A5_1234);
        check_eq("solo_m0_acks", ack_cnt[0], 2);
        check_eq("solo_m1_acks", ack_cnt[1], 0);

        // Reset while m1 holds the bus with stb high
        do_reset();
        slave_hang = 1'b1;
        qpush(1, mk(1'b0, 32'h0000_0008, 32'h0, 1'b0, 0));
        for (int i = 0; i < 6 && owner != 1; i++) cycle();
        #1 check_eq("pre_rst_stb", s_stb_o, 1'b1);
        do_reset();

        // Contention right after reset: m0 first, m1 handed over directly
        qpush(0, mk(1'b1, 32'h0000_0000, 32'h1111_0000, 1'b0, 0));
        qpush(1, mk(1'b1, 32'h0000_0004, 32'h2222_0004, 1'b0, 0));
        run_until_idle(50);
        check_eq("cont_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check_eq("cont_first", grant_log[0], 0);
            check_eq("cont_second", grant_log[1], 1);
        end
        check_eq("cont_handoff", handoffs, 1);

        // Round robin over 6 transactions
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qpush(0, mk(1'b1, 32'h10 + 32'(i * 4), $urandom, 1'b0, 0));
            qpush(1, mk(1'b0, 32'h20 + 32'(i * 4), 32'h0, 1'b0, 0));
        end
        run_until_idle(200);
        order = '0;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) order[i] = grant_log[i][0];
        check_eq("rr_ngrants", grant_log.size(), 6);
        check_eq("rr_order", order, 6'b101010);
        check_eq("rr_m0_acks", ack_cnt[0], 3);
        check_eq("rr_m1_acks", ack_cnt[1], 3);

        // Held grant: m1 does 3 beats under one cyc while m0 waits
        do_reset();
        qpush(1, mk(1'b1, 32'h0000_0030, 32'hB0B0_0001, 1'b1, 0));
        qpush(1, mk(1'b1, 32'h0000_0034, 32'hB0B0_0002, 1'b1, 0));
        qpush(1, mk(1'b0, 32'h0000_0030, 32'h0, 1'b0, 0));
        qpush(0, mk(1'b0, 32'h0000_0034, 32'h0, 1'b0, 2));
        run_until_idle(100);
        check_eq("held_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) check_eq("held_order", {grant_log[0][0], grant_log[1][0]}, 2'b10);
        check_eq("held_m1_acks", ack_cnt[1], 3);
        check_eq("held_m0_acks", ack_cnt[0], 1);
        check_eq("held_handoff", handoffs, 1);

        // Random traffic
        do_reset();
        rand_mode = 1'b1;
        repeat (1500) cycle();
        rand_mode = 1'b0;
        run_until_idle(500);

        // Hung slave
        do_reset();
        slave_hang = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_adr[0] = '0;
`ifdef LA_WB_ARB_TIMEOUT_EN
        stb_cycles = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (m0_ack) begin
                got = 1'b1;
                check_eq("to_dat", m0_rdat, 32'hDEAD_BEEF);
                check_eq("to_stb_forced", s_stb_o, 1'b0);
                check_eq("to_m1_ack", m1_ack, 1'b0);
            end else if (s_stb_o) begin
                stb_cycles++;
            end
        end
        check_eq("to_ack_seen", got, 1'b1);
        check_eq("to_stb_cycles", stb_cycles, Tmo);
        @(posedge clk);
        #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("to_sticky", timeout_o, 1'b1);
        check_eq("to_no_more_ack", m_ack, 2'b00);
`else
        acks = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_ack != 2'b00) acks++;
        end
        check_eq("hang_no_ack", acks, 0);
        check_eq("hang_timeout", timeout_o, 1'b0);
        check_eq("hang_stb_held", s_stb_o, 1'b1);
        @(posedge clk);
        #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
